ram_clr: RTL and testbench
==========================

RAM_CLR -- requirements
Module: ram_clr

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter ADDR_W, default 9, address width in bits; DEPTH = 2**ADDR_W words (default 512).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in  input  WIDTH  write data.
REQ-006 address  input  ADDR_W  read/write word address.
REQ-007 load  input  1  write enable; writes in to mem[address] at the rising edge.
REQ-008 clear  input  1  single-cycle request to zero the whole array.
REQ-009 out  output  WIDTH  read data.
REQ-010 busy  output  1  high while a clear sweep runs; accesses are refused.

Function
REQ-011 The block SHALL hold a DEPTH x WIDTH array plus an ADDR_W-bit sweep counter and a 2-state FSM: CLEAR, READY.
REQ-012 In READY, out SHALL equal mem[address] combinationally; a write is visible on out from the edge that performs it.
REQ-013 In READY, load=1 at a rising edge SHALL write in to mem[address]; load=0 leaves the array unchanged.
REQ-014 In CLEAR, each rising edge SHALL write 0 to mem[counter] and increment counter by 1.
REQ-015 CLEAR -> READY SHALL occur at the edge that zeroes word DEPTH-1; counter wraps to 0; CLEAR lasts exactly DEPTH cycles.
REQ-016 READY -> CLEAR SHALL occur on the edge where clear=1; counter starts at 0.
REQ-017 busy SHALL be 1 in CLEAR and 0 in READY.
REQ-018 While busy=1, out SHALL be 0 and load SHALL be ignored; no user write is performed or queued.
REQ-019 clear=1 while in CLEAR SHALL be ignored; the running sweep neither restarts nor extends.
REQ-020 clear=1 and load=1 on the same READY edge: clear wins, the write is dropped.
REQ-021 Address bits are used unmodified; all DEPTH addresses are valid, so no out-of-range case exists.

Reset
REQ-022 rst_n=0 SHALL immediately force state CLEAR, counter 0, busy 1, out 0, independent of clk.
REQ-023 Array contents are not reset directly; they are zeroed by the CLEAR sweep, which begins on the first rising edge after rst_n returns high.
REQ-024 rst_n asserted mid-sweep SHALL restart the sweep at word 0, giving a full DEPTH-cycle CLEAR after release.

Configuration
REQ-025 Macro RAM_CLR_BYPASS_EN SHALL control write-through.
REQ-026 With RAM_CLR_BYPASS_EN defined: in READY with load=1 and clear=0, out SHALL equal in combinationally in the same cycle, before the edge.
REQ-027 Without RAM_CLR_BYPASS_EN: out SHALL always show stored contents; new data appears only after the writing edge.

Verification (defaults WIDTH=16, ADDR_W=9)
REQ-028 rst_n low for 3 cycles, then high -> busy=1 and out=0 for exactly 512 rising edges, busy=0 afterwards; reads of addresses 0, 255 and 511 all return 0x0000.
REQ-029 READY, load=1, address=37, in=0xBEEF for one edge, then load=0 -> out=0xBEEF at address 37; address 38 still reads 0x0000.
REQ-030 After REQ-029, one-cycle clear pulse with load=1, address=38, in=0x1234 -> busy high for 512 edges; afterwards addresses 37 and 38 both read 0x0000.
REQ-031 During a sweep, load=1, address=5, in=0xFFFF every cycle, plus clear pulses -> sweep length is still 512 cycles; address 5 reads 0x0000 afterwards.
REQ-032 Assert rst_n low after 100 cycles of a sweep, release 2 cycles later -> busy=1 asynchronously during reset, then a further 512 cycles of busy; all words read 0x0000.
REQ-033 RAM_CLR_BYPASS_EN defined, READY, load=1, address=10, in=0x00A5 -> out=0x00A5 before the edge. Undefined: out=old mem[10] before the edge, 0x00A5 after it.

Source files
------------

// File: rtl/ram_clr.sv
// ram_clr: DEPTH x WIDTH RAM with a self-timed sweep that zeroes every word after reset or on request.
// Optional write-through of in to out during a write cycle: define RAM_CLR_BYPASS_EN.
module ram_clr #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] counter, counter_nxt;
  logic              user_wr;
  logic [WIDTH-1:0]  mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      counter <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
    end
  end

  // Sweep ends on the edge that zeroes the last word; counter wraps back to 0 by itself.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    user_wr     = 1'b0;
    case (state)
      CLEAR: begin
        counter_nxt = counter + 1'b1;
        if (counter == '1) state_nxt = READY;
      end
      READY: begin
        if (clear) begin
          state_nxt   = CLEAR;
          counter_nxt = '0;
        end else begin
          user_wr = load;
        end
      end
    endcase
  end

  // Array is not reset; the sweep is the only path that zeroes it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[counter] <= '0;
    else if (user_wr)   mem[address] <= in;
  end

  always_comb begin
    busy = (state == CLEAR);
    if (busy) out = '0;
`ifdef RAM_CLR_BYPASS_EN
    else if (user_wr) out = in;
`endif
    else out = mem[address];
  end

endmodule

// File: tb/tb_ram_clr.sv
// Scoreboard bench for ram_clr: stimulus pushes predicted busy/out per cycle, a negedge monitor compares.
module tb_ram_clr;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WIDTH-1:0]  in_d = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic              load = 1'b0;
  logic              clear = 1'b0;
  logic [WIDTH-1:0]  out;
  logic              busy;

  ram_clr #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_d), .address(addr),
    .load(load), .clear(clear), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             busy;
    logic [WIDTH-1:0] out;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: contents plus number of edges left in a running sweep.
  logic [WIDTH-1:0] model_mem [DEPTH];
  int busy_left = DEPTH;

  function automatic void check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("busy", {15'd0, busy}, {15'd0, e.busy});
      check("out", out, e.out);
    end
  end

  // One clock cycle: drive, predict, take the edge, advance the model.
  task automatic step(input bit rn, input bit ld, input bit cl,
                      input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    exp_t e;
    rst_n = rn; load = ld; clear = cl; addr = a; in_d = d;
    if (!rn) busy_left = DEPTH;
    e.busy = (busy_left > 0);
    if (e.busy) e.out = '0;
`ifdef RAM_CLR_BYPASS_EN
    else if (ld && !cl) e.out = d;
`endif
    else e.out = model_mem[a];
    exp_q.push_back(e);
    @(posedge clk);
    if (rn) begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0)
          for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      end else if (cl) begin
        busy_left = DEPTH;
      end else if (ld) begin
        model_mem[a] = d;
      end
    end
    #1;
  endtask

  task automatic idle_read(input logic [ADDR_W-1:0] a);
    step(1'b1, 1'b0, 1'b0, a, 16'h0);
  endtask

  // Counts edges with busy high; noisy mode hammers address 5 and pulses clear.
  task automatic count_sweep(input bit noisy);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      if (noisy) step(1'b1, 1'b1, ($urandom % 8) == 0, 9'd5, 16'hFFFF);
      else       step(1'b1, 1'b0, 1'b0, ADDR_W'($urandom), 16'($urandom));
      cnt++;
    end
    check("sweep_len", 16'(cnt), 16'(DEPTH));
  endtask

  task automatic async_reset_check();
    rst_n = 1'b0;
    busy_left = DEPTH;
    #1;
    check("async_busy", {15'd0, busy}, 16'd1);
    check("async_out", out, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    #1;
    check("rst_busy", {15'd0, busy}, 16'd1);
    check("rst_out", out, 16'h0);
    #5;
    @(posedge clk); #1;

    // Power-up sweep after a 3-cycle reset.
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0);
    count_sweep(1'b0);
    idle_read(9'd0); idle_read(9'd255); idle_read(9'd511);

    // Single write, then neighbour read.
    step(1'b1, 1'b1, 1'b0, 9'd37, 16'hBEEF);
    idle_read(9'd37); idle_read(9'd38);

    // Clear wins over a simultaneous write.
    step(1'b1, 1'b1, 1'b1, 9'd38, 16'h1234);
    count_sweep(1'b0);
    idle_read(9'd37); idle_read(9'd38);

    // Writes and clear pulses during a sweep are ignored.
    step(1'b1, 1'b0, 1'b1, 9'd0, 16'h0);
    count_sweep(1'b1);
    idle_read(9'd5);

    // Reset 100 cycles into a sweep restarts it.
    step(1'b1, 1'b0, 1'b1, 9'd0, 16'h0);
    repeat (99) step(1'b1, 1'b0, 1'b0, 9'd0, 16'h0);
    async_reset_check();
    repeat (2) step(1'b0, 1'b0, 1'b0, '0, '0);
    count_sweep(1'b0);
    for (int i = 0; i < DEPTH; i++) idle_read(ADDR_W'(i));

    // Write-through behaviour at address 10.
    step(1'b1, 1'b1, 1'b0, 9'd10, 16'h1111);
    idle_read(9'd10);
    step(1'b1, 1'b1, 1'b0, 9'd10, 16'h00A5);
    idle_read(9'd10);

    // Asynchronous reset from READY.
    async_reset_check();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    count_sweep(1'b0);

    // Randomized traffic with occasional clears and resets.
    for (int n = 0; n < 4000; n++) begin
      logic [ADDR_W-1:0] a;
      int r;
      r = $urandom % 1000;
      a = ($urandom % 2 == 0) ? ADDR_W'($urandom % 16) : ADDR_W'($urandom);
      if (r < 2) begin
        step(1'b0, 1'b0, 1'b0, a, '0);
        step(1'b0, 1'b0, 1'b0, a, '0);
      end else begin
        step(1'b1, ($urandom % 2) == 1, r < 6, a, 16'($urandom));
      end
    end

    @(negedge clk); #1;
    check("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
